instr_fetch_unit: RTL

- Per-core instruction sequencer that sits directly upstream of one dualcore processor port.
- Holds a small loadable program memory and issues one {opcode, data1_addr, data2_addr} vector per clock to the core's vector_in.
- Stalls while the core reports HALT on its status output, and raises the core's fetching input while issuing.
- Two instances feed the two cores, replacing the bench-driven instruction arrays.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Per-core instruction sequencer: a loadable program memory that issues one
// {opcode, data1_addr, data2_addr} vector per clock and stalls while the core reports HALT.
module instr_fetch_unit #(
  parameter int unsigned ALU_OPCODE_WIDTH  = 4,
  parameter int unsigned ADDRESS_WIDTH     = 4,
  parameter int unsigned INSTRUCTION_WIDTH = ALU_OPCODE_WIDTH + 2 * ADDRESS_WIDTH,
  parameter int unsigned PC_WIDTH          = 4,
  parameter int unsigned PROG_DEPTH        = 2 ** PC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [PC_WIDTH-1:0]          load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  input  logic [PC_WIDTH:0]            prog_len,
  input  logic                         start,
  input  logic                         loop_en,
  input  logic                         status_in,
  output logic [INSTRUCTION_WIDTH-1:0] vector_out,
  output logic                         fetching,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         done,
  output logic [7:0]                   issued_count,
  output logic                         load_err
);

  typedef enum logic [1:0] {StIdle, StRun, StStall, StDone} state_e;

  localparam logic [PC_WIDTH:0] DepthLen = (PC_WIDTH + 1)'(PROG_DEPTH);
  localparam logic [PC_WIDTH:0] OneLen   = (PC_WIDTH + 1)'(1);

  state_e                       state_q;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [PC_WIDTH:0]            len_q;
  logic [INSTRUCTION_WIDTH-1:0] vec_q;
  logic                         fetch_q;
  logic                         done_q;
  logic [7:0]                   cnt_q;
  logic                         lerr_q;

  logic [INSTRUCTION_WIDTH-1:0] mem [PROG_DEPTH];

  logic              loadable;
  logic              mem_we;
  logic [PC_WIDTH:0] len_clamped;
  logic              last_instr;

  assign loadable    = (state_q == StIdle) || (state_q == StDone);
  assign mem_we      = load_en && loadable;
  assign len_clamped = (prog_len > DepthLen) ? DepthLen : prog_len;
  assign last_instr  = ({1'b0, pc_q} == (len_q - OneLen));

  // No reset on the array so it stays a plain distributed RAM and survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      vec_q   <= '0;
      fetch_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lerr_q  <= 1'b0;
    end else begin
      lerr_q <= load_en && !loadable;
      unique case (state_q)
        StIdle, StDone: begin
          fetch_q <= 1'b0;
          vec_q   <= '0;
          if (start) begin
            len_q  <= len_clamped;
            pc_q   <= '0;
            cnt_q  <= '0;
            done_q <= (len_clamped == '0);
            state_q <= (len_clamped == '0) ? StDone : StRun;
          end else if (state_q == StDone) begin
            done_q <= 1'b1;
          end
        end
        StRun: begin
          if (status_in) begin
            // HALT wins over issuing, including the last instruction.
            fetch_q <= 1'b0;
            state_q <= StStall;
          end else begin
            vec_q   <= mem[pc_q];
            fetch_q <= 1'b1;
            if (cnt_q != 8'hFF) begin
              cnt_q <= cnt_q + 8'd1;
            end
            if (last_instr) begin
              if (loop_en) begin
                pc_q <= '0;
              end else begin
                state_q <= StDone;
              end
            end else begin
              pc_q <= pc_q + PC_WIDTH'(1);
            end
          end
        end
        StStall: begin
          fetch_q <= 1'b0;
          if (!status_in) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vector_out   = vec_q;
  assign fetching     = fetch_q;
  assign pc_out       = pc_q;
  assign done         = done_q;
  assign issued_count = cnt_q;
  assign load_err     = lerr_q;

endmodule
